// File: rtl/pwm_deadtime.sv
// Complementary PWM modulator with double-buffered duty/period and programmable dead time.
// Optional fault latch is compiled in with `define PWM_FAULT_EN.
module pwm_deadtime #(
  parameter int signal_width = 12,
  parameter int dt_width     = 8
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [signal_width-1:0] duty,
  input  logic [signal_width-1:0] period,
  input  logic [dt_width-1:0]     deadtime,
  output logic                    pwm_h,
  output logic                    pwm_l,
  output logic                    period_start,
  output logic [signal_width-1:0] counter
`ifdef PWM_FAULT_EN
  ,
  input  logic                    fault,
  output logic                    fault_latched
`endif
);

  typedef enum logic [2:0] {OFF, DT_H, H_ON, DT_L, L_ON} state_t;

  localparam logic [signal_width-1:0] CNT_ONE  = 1;
  localparam logic [signal_width:0]   DUTY_ONE = 1;
  localparam logic [dt_width-1:0]     DT_ONE   = 1;

  state_t                  state;
  logic [signal_width-1:0] duty_sh;
  logic [signal_width-1:0] period_sh;
  logic [signal_width-1:0] counter_next;
  logic [signal_width:0]   duty_eff;
  logic [dt_width-1:0]     dt_cnt;
  logic [dt_width-1:0]     dt_load;
  logic                    raw;
  logic                    kill;

  always_comb begin
    counter_next = '0;
    if (enable && (counter < period_sh))
      counter_next = counter + CNT_ONE;
  end

  // Duty above the terminal count saturates to a full carrier, i.e. 100 %.
  always_comb begin
    duty_eff = {1'b0, duty_sh};
    if (duty_sh > period_sh)
      duty_eff = {1'b0, period_sh} + DUTY_ONE;
  end

  assign dt_load = (deadtime == '0) ? DT_ONE : deadtime;

`ifdef PWM_FAULT_EN
  assign kill = !enable || fault || fault_latched;

  always_ff @(posedge aclk) begin
    if (reset)
      fault_latched <= 1'b0;
    else
      fault_latched <= enable && (fault_latched || fault);
  end
`else
  assign kill = !enable;
`endif

  // Shadow registers only reload on the last carrier cycle, so a period is never split.
  always_ff @(posedge aclk) begin
    if (reset) begin
      counter      <= '0;
      duty_sh      <= '0;
      period_sh    <= '0;
      period_start <= 1'b0;
      raw          <= 1'b0;
    end else begin
      counter      <= counter_next;
      period_start <= enable && (counter_next == '0);
      raw          <= ({1'b0, counter} < duty_eff);
      if (!enable || (counter == period_sh)) begin
        duty_sh   <= duty;
        period_sh <= period;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state  <= OFF;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else if (kill) begin
      state <= OFF;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          state  <= DT_L;
          dt_cnt <= dt_load;
          pwm_h  <= 1'b0;
          pwm_l  <= 1'b0;
        end
        DT_L: begin
          if (raw) begin
            state  <= DT_H;
            dt_cnt <= dt_load;
          end else if (dt_cnt <= DT_ONE) begin
            state <= L_ON;
            pwm_l <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - DT_ONE;
          end
        end
        L_ON: begin
          if (raw) begin
            state  <= DT_H;
            dt_cnt <= dt_load;
            pwm_l  <= 1'b0;
          end
        end
        DT_H: begin
          if (!raw) begin
            state  <= DT_L;
            dt_cnt <= dt_load;
          end else if (dt_cnt <= DT_ONE) begin
            state <= H_ON;
            pwm_h <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - DT_ONE;
          end
        end
        H_ON: begin
          if (!raw) begin
            state  <= DT_L;
            dt_cnt <= dt_load;
            pwm_h  <= 1'b0;
          end
        end
        default: begin
          state <= OFF;
          pwm_h <= 1'b0;
          pwm_l <= 1'b0;
        end
      endcase
    end
  end

endmodule
